laser_scan_ctrl: RTL and testbench

LASER_SCAN_CTRL -- requirements
Module: laser_scan_ctrl

---
 rtl/laser_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_laser_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/laser_scan_ctrl.sv
// Alternating C1/C2 centre search: scans all 256 candidate centres for one circle
// while the other stays fixed, commits the strict best, and repeats until no gain.
module laser_scan_ctrl #(
  parameter int MAX_ITER = 4,
  parameter int CNT_W    = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             REQ_VALID,
  input  logic             REQ_READY,
  output logic             REQ_SEL,
  output logic [3:0]       REQ_X,
  output logic [3:0]       REQ_Y,
  output logic [3:0]       FIX_X,
  output logic [3:0]       FIX_Y,
  input  logic             RSP_VALID,
  input  logic [CNT_W-1:0] RSP_CNT,
  output logic [3:0]       C1X,
  output logic [3:0]       C1Y,
  output logic [3:0]       C2X,
  output logic [3:0]       C2Y,
  output logic [CNT_W-1:0] BEST_CNT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t           state_q, state_d;
  logic [3:0]       c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic [CNT_W-1:0] best_q, best_d, pass_best_q, pass_best_d;
  logic [3:0]       pass_x_q, pass_x_d, pass_y_q, pass_y_d;
  logic             imp_q, imp_d, pair_imp_q, pair_imp_d;
  logic [3:0]       iter_q, iter_d;
  logic             sel_q, sel_d;
  logic [3:0]       cx_q, cx_d, cy_q, cy_d;

  logic             better, nimp;
  logic [CNT_W-1:0] nbest;
  logic [3:0]       npx, npy;

  always_comb begin
    state_d     = state_q;
    c1x_d       = c1x_q;
    c1y_d       = c1y_q;
    c2x_d       = c2x_q;
    c2y_d       = c2y_q;
    best_d      = best_q;
    pass_best_d = pass_best_q;
    pass_x_d    = pass_x_q;
    pass_y_d    = pass_y_q;
    imp_d       = imp_q;
    pair_imp_d  = pair_imp_q;
    iter_d      = iter_q;
    sel_d       = sel_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    REQ_VALID   = 1'b0;
    BUSY        = 1'b1;
    DONE        = 1'b0;

    // Strict compare keeps the earliest candidate on ties.
    better = (RSP_CNT > pass_best_q);
    nbest  = better ? RSP_CNT : pass_best_q;
    npx    = better ? cx_q : pass_x_q;
    npy    = better ? cy_q : pass_y_q;
    nimp   = imp_q | better;

    case (state_q)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          c1x_d       = 4'd4;
          c1y_d       = 4'd4;
          c2x_d       = 4'd11;
          c2y_d       = 4'd11;
          best_d      = '0;
          pass_best_d = '0;
          pass_x_d    = '0;
          pass_y_d    = '0;
          imp_d       = 1'b0;
          pair_imp_d  = 1'b0;
          iter_d      = '0;
          sel_d       = 1'b0;
          cx_d        = '0;
          cy_d        = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        REQ_VALID = 1'b1;
        if (REQ_READY) state_d = WAIT;
      end
      WAIT: begin
        if (RSP_VALID) begin
          pass_best_d = nbest;
          pass_x_d    = npx;
          pass_y_d    = npy;
          state_d     = ISSUE;
          if (!(cx_q == 4'hF && cy_q == 4'hF)) begin
            imp_d = nimp;
            cx_d  = cx_q + 4'd1;
            if (cx_q == 4'hF) cy_d = cy_q + 4'd1;
          end else begin
            // Pass end: commit only if this pass found a strictly better centre.
            if (nimp) begin
              best_d = nbest;
              if (sel_q) begin
                c2x_d = npx;
                c2y_d = npy;
              end else begin
                c1x_d = npx;
                c1y_d = npy;
              end
            end
            imp_d = 1'b0;
            cx_d  = '0;
            cy_d  = '0;
            if (!sel_q) begin
              pair_imp_d = nimp;
              sel_d      = 1'b1;
            end else begin
              iter_d = iter_q + 4'd1;
              sel_d  = 1'b0;
              if (!(pair_imp_q || nimp) || (iter_q + 4'd1) >= 4'(MAX_ITER)) begin
                state_d = FINISH;
              end
            end
          end
        end
      end
      FINISH: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      best_q      <= '0;
      pass_best_q <= '0;
      pass_x_q    <= '0;
      pass_y_q    <= '0;
      imp_q       <= 1'b0;
      pair_imp_q  <= 1'b0;
      iter_q      <= '0;
      sel_q       <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
    end else begin
      state_q     <= state_d;
      c1x_q       <= c1x_d;
      c1y_q       <= c1y_d;
      c2x_q       <= c2x_d;
      c2y_q       <= c2y_d;
      best_q      <= best_d;
      pass_best_q <= pass_best_d;
      pass_x_q    <= pass_x_d;
      pass_y_q    <= pass_y_d;
      imp_q       <= imp_d;
      pair_imp_q  <= pair_imp_d;
      iter_q      <= iter_d;
      sel_q       <= sel_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
    end
  end

  assign REQ_SEL  = sel_q;
  assign REQ_X    = cx_q;
  assign REQ_Y    = cy_q;
  assign FIX_X    = sel_q ? c1x_q : c2x_q;
  assign FIX_Y    = sel_q ? c1y_q : c2y_q;
  assign C1X      = c1x_q;
  assign C1Y      = c1y_q;
  assign C2X      = c2x_q;
  assign C2Y      = c2y_q;
  assign BEST_CNT = best_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Randomized bench for laser_scan_ctrl: a transaction-level search model predicts every
// request and committed result; literal expectations pin the directed scenarios.
module tb_laser_scan_ctrl;
  localparam int MAX_ITER = 4;
  localparam int CNT_W    = 6;

  logic             CLK = 1'b0;
  logic             RST, START, REQ_READY, RSP_VALID;
  logic [CNT_W-1:0] RSP_CNT;
  logic             REQ_VALID, REQ_SEL, BUSY, DONE;
  logic [3:0]       REQ_X, REQ_Y, FIX_X, FIX_Y, C1X, C1Y, C2X, C2Y;
  logic [CNT_W-1:0] BEST_CNT;

  laser_scan_ctrl #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SEL(REQ_SEL),
    .REQ_X(REQ_X), .REQ_Y(REQ_Y), .FIX_X(FIX_X), .FIX_Y(FIX_Y),
    .RSP_VALID(RSP_VALID), .RSP_CNT(RSP_CNT),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .BEST_CNT(BEST_CNT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Search model: candidate index 0..255 with x = idx % 16, y = idx / 16.
  int m_c1x, m_c1y, m_c2x, m_c2y, m_best, m_sel, m_idx;
  int m_pb, m_pp, m_imp, m_pair, m_iter, m_passes;
  bit m_fin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start();
    m_c1x = 4; m_c1y = 4; m_c2x = 11; m_c2y = 11;
    m_best = 0; m_sel = 0; m_idx = 0; m_pb = 0; m_pp = 0;
    m_imp = 0; m_pair = 0; m_iter = 0; m_passes = 0; m_fin = 0;
  endtask

  task automatic model_rsp(input int v);
    if (v > m_pb) begin
      m_pb = v; m_pp = m_idx; m_imp = 1;
    end
    if (m_idx < 255) begin
      m_idx++;
    end else begin
      m_passes++;
      if (m_imp != 0) begin
        m_best = m_pb;
        if (m_sel == 0) begin m_c1x = m_pp % 16; m_c1y = m_pp / 16; end
        else            begin m_c2x = m_pp % 16; m_c2y = m_pp / 16; end
      end
      if (m_sel == 0) begin
        m_pair = m_imp;
        m_sel  = 1;
      end else begin
        m_iter++;
        if ((m_pair == 0 && m_imp == 0) || m_iter >= MAX_ITER) m_fin = 1;
        m_sel = 0;
      end
      m_idx = 0;
      m_imp = 0;
      m_pb  = m_best;
    end
  endtask

  function automatic int resp_val(input int mode, input int sel, input int x, input int y,
                                  input int pass);
    case (mode)
      0:       return 5;
      1:       return (sel == 0 && x == 7 && y == 3) ? 20 : 1;
      2:       return (x == 15 && y == 15) ? pass + 1 : 0;
      default: return int'($urandom_range(0, (1 << CNT_W) - 1));
    endcase
  endfunction

  function automatic logic [31:0] exp_status(input bit busy, input bit done, input bit rv);
    return {7'd0, busy, done, rv, 4'(m_c1x), 4'(m_c1y), 4'(m_c2x), 4'(m_c2y), 6'(m_best)};
  endfunction

  function automatic logic [31:0] act_status();
    return {7'd0, BUSY, DONE, REQ_VALID, C1X, C1Y, C2X, C2Y, BEST_CNT};
  endfunction

  // Drives one run as the coverage engine; checks DUT against the model every cycle.
  task automatic run(input int mode, input int stall_pct, input bit spurious,
                     input int abort_after, input int start_poke, output int cycles);
    int pending, lat, v, cyc;
    bit finished;
    pending = 0; lat = 0; v = 0; cyc = 0; finished = 0;
    @(negedge CLK);
    START = 1'b1;
    model_start();
    @(negedge CLK);
    START = 1'b0;
    cyc = 1;
    while (!finished) begin
      if (cyc > 20000) begin
        chk("run_budget", 32'(cyc), 32'd20000);
        finished = 1;
      end else if (abort_after != 0 && cyc == abort_after) begin
        finished = 1;
      end else if (m_fin) begin
        chk("done_cycle", act_status(), exp_status(1'b1, 1'b1, 1'b0));
        cycles = cyc;
        REQ_READY = 1'b0; RSP_VALID = 1'b0;
        @(negedge CLK);
        chk("after_done", act_status(), exp_status(1'b0, 1'b0, 1'b0));
        finished = 1;
      end else begin
        chk("status", act_status(), exp_status(1'b1, 1'b0, pending == 0));
        if (pending == 0) begin
          chk("request", {15'd0, REQ_SEL, REQ_X, REQ_Y, FIX_X, FIX_Y},
              {15'd0, 1'(m_sel), 4'(m_idx % 16), 4'(m_idx / 16),
               4'(m_sel != 0 ? m_c1x : m_c2x), 4'(m_sel != 0 ? m_c1y : m_c2y)});
        end
        REQ_READY = 1'b0; RSP_VALID = 1'b0; RSP_CNT = '0;
        START = (cyc == start_poke);
        if (pending != 0) begin
          if (lat == 0) begin
            RSP_VALID = 1'b1;
            RSP_CNT   = CNT_W'(v);
            model_rsp(v);
            pending   = 0;
          end else begin
            lat--;
          end
        end else if (int'($urandom_range(0, 99)) < stall_pct) begin
          if (spurious) begin
            RSP_VALID = 1'b1;
            RSP_CNT   = '1;
          end
        end else begin
          REQ_READY = 1'b1;
          pending   = 1;
          lat       = (stall_pct != 0) ? int'($urandom_range(0, 2)) : 0;
          v         = resp_val(mode, m_sel, m_idx % 16, m_idx / 16, m_passes);
        end
        @(negedge CLK);
        cyc++;
      end
    end
    REQ_READY = 1'b0; RSP_VALID = 1'b0; RSP_CNT = '0; START = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {11'd0, REQ_VALID, REQ_SEL, BUSY, DONE, REQ_X, REQ_Y, FIX_X, FIX_Y},
        32'd0);
    chk({name, "_res"}, {10'd0, C1X, C1Y, C2X, C2Y, BEST_CNT}, 32'd0);
  endtask

  task automatic chk_final(input string name, input int c1x, input int c1y, input int c2x,
                           input int c2y, input int best, input int passes);
    chk({name, "_result"}, {10'd0, C1X, C1Y, C2X, C2Y, BEST_CNT},
        {10'd0, 4'(c1x), 4'(c1y), 4'(c2x), 4'(c2y), 6'(best)});
    chk({name, "_passes"}, 32'(m_passes), 32'(passes));
  endtask

  initial begin
    int cycles;
    cycles = 0;
    RST = 1'b1; START = 1'b0; REQ_READY = 1'b0; RSP_VALID = 1'b0; RSP_CNT = '0;

    // Reset, with START asserted while reset is held.
    repeat (2) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    chk_all_zero("reset_start");
    RST = 1'b0; START = 1'b0;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset_idle");

    // Constant engine, zero-wait: first candidate wins, 4 passes, 2048-cycle run.
    run(0, 0, 1'b0, 0, 0, cycles);
    chk_final("const5", 0, 0, 11, 11, 5, 4);
    chk("const5_latency", 32'((cycles >= 2045 && cycles <= 2051) ? 1 : 0), 32'd1);
    repeat (3) @(negedge CLK);
    chk("const5_hold", {10'd0, C1X, C1Y, C2X, C2Y, BEST_CNT},
        {10'd0, 4'd0, 4'd0, 4'd11, 4'd11, 6'd5});

    // Single peak for C1, with stalls, spurious responses in ISSUE and START while busy.
    run(1, 30, 1'b1, 0, 7, cycles);
    chk_final("peak", 7, 3, 11, 11, 20, 4);

    // Growing value only at (15,15): every pass improves, stops on the iteration limit.
    run(2, 0, 1'b0, 0, 0, cycles);
    chk_final("grow", 15, 15, 15, 15, 8, 8);

    // Abort mid-pass with reset, then a fresh randomized run from the initial centres.
    run(0, 0, 1'b0, 300, 5, cycles);
    RST = 1'b1;
    @(negedge CLK);
    chk_all_zero("mid_reset");
    RST = 1'b0;
    @(negedge CLK);
    chk_all_zero("mid_reset_idle");
    run(3, 20, 1'b1, 0, 0, cycles);
    chk("rand1_final", {10'd0, C1X, C1Y, C2X, C2Y, BEST_CNT},
        {10'd0, 4'(m_c1x), 4'(m_c1y), 4'(m_c2x), 4'(m_c2y), 6'(m_best)});

    run(3, 0, 1'b0, 0, 0, cycles);
    chk("rand2_final", {10'd0, C1X, C1Y, C2X, C2Y, BEST_CNT},
        {10'd0, 4'(m_c1x), 4'(m_c1y), 4'(m_c2x), 4'(m_c2y), 6'(m_best)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
